seq_generator: RTL

SEQ_GENERATOR -- requirements
Module: seq_generator

---
 rtl/seq_pkg.sv | 24 ++
 rtl/seq_shift_reg.sv | 48 ++++
 rtl/seq_generator.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator.
// Optional feature macro: SEQ_GEN_GAP_EN (adds the GAP state between repetitions).
package seq_pkg;

    localparam int SEQ_W_DEF  = 8;
    localparam int SEQ_RW_DEF = 4;
    localparam int GAP_W      = 4;

`ifdef SEQ_GEN_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_GAP    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd3
    } state_t;
`endif

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable MSB-first shift register. The active len bits are left-aligned
// on load, so bit_out is always the next bit to send; idx counts the bits
// still to go and last_bit flags the final one of the pass.
module seq_shift_reg
#(
    parameter int W  = 8,
    parameter int LW = $clog2(W + 1)
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic          shift,
    input  logic [W-1:0]  load_pattern,
    input  logic [LW-1:0] load_len,
    output logic          bit_out,
    output logic          last_bit
);

    logic [W-1:0]  sreg;
    logic [LW-1:0] idx;
    logic [LW-1:0] align_sh;

    // load_len is already clamped to W by the caller, so this never underflows
    assign align_sh = LW'(W) - load_len;

    // Shift data and bit-index down-counter; load wins over shift for a seamless reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg <= '0;
            idx  <= '0;
        end else if (clear) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= load_pattern << align_sh;
            idx  <= load_len - LW'(1);
        end else if (shift) begin
            sreg <= {sreg[W-2:0], 1'b0};
            idx  <= idx - LW'(1);
        end
    end

    assign bit_out  = sreg[W-1];
    assign last_bit = (idx == '0);

endmodule

// File: rtl/seq_generator.sv
// Serial pattern generator: sends len bits of pattern MSB-first, reps times,
// then pulses done. Optional feature macro: SEQ_GEN_GAP_EN adds a gap_len
// input and idle GAP cycles between repetitions.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for start; inputs captured on start
// ST_SHIFT  | one pattern bit per clock on x with valid=1
// ST_GAP    | idle spacing between repetitions (SEQ_GEN_GAP_EN only)
// ST_FINISH | one-cycle done pulse, then back to idle
module seq_generator
    import seq_pkg::*;
#(
    parameter int W  = SEQ_W_DEF,
    parameter int RW = SEQ_RW_DEF,
    localparam int LW = $clog2(W + 1)
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     pattern,
    input  logic [LW-1:0]    len,
    input  logic [RW-1:0]    reps,
`ifdef SEQ_GEN_GAP_EN
    input  logic [GAP_W-1:0] gap_len,
`endif
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    pat_q;
    logic [LW-1:0]   len_q;
    logic [RW-1:0]   reps_left;
    logic [LW-1:0]   len_c;
    logic            take_start;
    logic            sr_load;
    logic            sr_shift;
    logic            sr_clear;
    logic            bit_out;
    logic            last_bit;
    logic [W-1:0]    ld_pat;
    logic [LW-1:0]   ld_len;
`ifdef SEQ_GEN_GAP_EN
    logic [GAP_W-1:0] gap_len_q;
    logic [GAP_W-1:0] gap_cnt;
`endif

    assign len_c  = (len > LW'(W)) ? LW'(W) : len;
    assign ld_pat = take_start ? pattern : pat_q;
    assign ld_len = take_start ? len_c   : len_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and shifter control; abort overrides everything, including start.
    always_comb begin
        state_nx   = state;
        take_start = 1'b0;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_clear   = 1'b0;
        if (abort) begin
            state_nx = ST_IDLE;
            sr_clear = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        take_start = 1'b1;
                        if (len_c == '0 || reps == '0) begin
                            state_nx = ST_FINISH;
                        end else begin
                            state_nx = ST_SHIFT;
                            sr_load  = 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    sr_shift = 1'b1;
                    if (last_bit) begin
                        if (reps_left > RW'(1)) begin
`ifdef SEQ_GEN_GAP_EN
                            if (gap_len_q != '0) begin
                                state_nx = ST_GAP;
                            end else begin
                                sr_load = 1'b1;
                            end
`else
                            sr_load = 1'b1;
`endif
                        end else begin
                            state_nx = ST_FINISH;
                        end
                    end
                end
`ifdef SEQ_GEN_GAP_EN
                ST_GAP: begin
                    if (gap_cnt <= GAP_W'(1)) begin
                        state_nx = ST_SHIFT;
                        sr_load  = 1'b1;
                    end
                end
`endif
                ST_FINISH: begin
                    state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    // Captured configuration, remaining-reps and gap down-counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q     <= '0;
            len_q     <= '0;
            reps_left <= '0;
`ifdef SEQ_GEN_GAP_EN
            gap_len_q <= '0;
            gap_cnt   <= '0;
`endif
        end else if (abort) begin
            reps_left <= '0;
`ifdef SEQ_GEN_GAP_EN
            gap_cnt   <= '0;
`endif
        end else begin
            if (take_start) begin
                pat_q     <= pattern;
                len_q     <= len_c;
                reps_left <= reps;
`ifdef SEQ_GEN_GAP_EN
                gap_len_q <= gap_len;
`endif
            end else if (state == ST_SHIFT && last_bit) begin
                reps_left <= reps_left - RW'(1);
            end
`ifdef SEQ_GEN_GAP_EN
            if (state == ST_SHIFT && state_nx == ST_GAP) begin
                gap_cnt <= gap_len_q;
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
`endif
        end
    end

    seq_shift_reg #(
        .W  (W),
        .LW (LW)
    ) u_shift (
        .clk          (clk),
        .reset        (reset),
        .clear        (sr_clear),
        .load         (sr_load),
        .shift        (sr_shift),
        .load_pattern (ld_pat),
        .load_len     (ld_len),
        .bit_out      (bit_out),
        .last_bit     (last_bit)
    );

    assign valid = (state == ST_SHIFT);
    assign x     = valid & bit_out;
    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_FINISH);

endmodule
